// File: rtl/chan_dff_bank_pkg.sv
// Shared constants for the channel register bank: scan FSM encodings,
// default geometry and the channel-index width helper.
package chan_dff_bank_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_NCH   = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Channel-index width; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chan_dff_bank_chan_dff.sv
// One WIDTH-bit channel register: async active-low reset, then synchronous
// clear, preset and load in that priority order.
module chan_dff #(
    parameter int               WIDTH      = 4,
    parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             pst,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Channel state update with clear > preset > load priority.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q <= {WIDTH{1'b0}};
        end else if (clr) begin
            q <= {WIDTH{1'b0}};
        end else if (pst) begin
            q <= PRESET_VAL;
        end else if (ld) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/chan_dff_bank.sv
// Bank of NCH channel registers with a registered random-access read port
// and a sequencer that streams every channel out in index order.
module chan_dff_bank
    import chan_dff_bank_pkg::*;
#(
    parameter int               WIDTH      = DEF_WIDTH,
    parameter int               NCH        = DEF_NCH,
    parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}},
    localparam int              SELW       = sel_width(NCH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [SELW-1:0]  wr_ch,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [NCH-1:0]   clr,
    input  logic [NCH-1:0]   pst,
    input  logic [SELW-1:0]  rd_ch,
    output logic [WIDTH-1:0] rd_data,
    input  logic             scan_start,
    output logic             scan_busy,
    output logic             scan_valid,
    output logic [SELW-1:0]  scan_ch,
    output logic [WIDTH-1:0] scan_data,
    output logic             scan_done
);

    // Terminal count compared directly, so NCH need not be a power of two.
    localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);

    logic [WIDTH-1:0] chan_q_s [NCH];
    logic [WIDTH-1:0] rd_mux_s;
    logic [WIDTH-1:0] scan_mux_s;
    logic [1:0]       state_r;
    logic [SELW-1:0]  cnt_r;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        // An out-of-range wr_ch matches no channel, so the write is dropped.
        logic ld_s;
        assign ld_s = wr_en & (wr_ch == SELW'(i));

        chan_dff #(
            .WIDTH      (WIDTH),
            .PRESET_VAL (PRESET_VAL)
        ) u_chan (
            .clock   (clock),
            .reset_n (reset_n),
            .clr     (clr[i]),
            .pst     (pst[i]),
            .ld      (ld_s),
            .d       (wr_data),
            .q       (chan_q_s[i])
        );
    end

    // Read and scan selectors; an index beyond the last channel yields zero.
    always_comb begin
        rd_mux_s   = {WIDTH{1'b0}};
        scan_mux_s = {WIDTH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            if (rd_ch == SELW'(i)) begin
                rd_mux_s = chan_q_s[i];
            end else begin
                rd_mux_s = rd_mux_s;
            end
            if (cnt_r == SELW'(i)) begin
                scan_mux_s = chan_q_s[i];
            end else begin
                scan_mux_s = scan_mux_s;
            end
        end
    end

    // Registered read port, sees channel values from before this edge's update.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= {WIDTH{1'b0}};
        end else begin
            rd_data <= rd_mux_s;
        end
    end

    // Scan sequencer: one beat per cycle for channels 0..NCH-1, then a done pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {SELW{1'b0}};
            scan_busy  <= 1'b0;
            scan_valid <= 1'b0;
            scan_ch    <= {SELW{1'b0}};
            scan_data  <= {WIDTH{1'b0}};
            scan_done  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    scan_done <= 1'b0;
                    if (scan_start) begin
                        state_r   <= ST_SCAN;
                        cnt_r     <= {SELW{1'b0}};
                        scan_busy <= 1'b1;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    scan_valid <= 1'b1;
                    scan_ch    <= cnt_r;
                    scan_data  <= scan_mux_s;
                    if (cnt_r == LAST_CH) begin
                        cnt_r   <= {SELW{1'b0}};
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r   <= cnt_r + 1'b1;
                    end
                end
                ST_DONE: begin
                    scan_valid <= 1'b0;
                    scan_done  <= 1'b1;
                    scan_busy  <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    cnt_r      <= {SELW{1'b0}};
                    scan_busy  <= 1'b0;
                    scan_valid <= 1'b0;
                    scan_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chan_dff_bank.sv
// Bench for chan_dff_bank: a default 4x4 bank (A) and a 3-channel 8-bit bank (B)
// run side by side against a cycle-level behavioural model of the bank.
module tb_chan_dff_bank;

    logic       clk;
    logic       reset_n;
    logic       wr_en_v   [2];
    logic [1:0] wr_ch_v   [2];
    logic [7:0] wr_data_v [2];
    logic [3:0] clr_v     [2];
    logic [3:0] pst_v     [2];
    logic [1:0] rd_ch_v   [2];
    logic       ss_v      [2];

    logic [3:0] a_rd_data, a_scan_data;
    logic [1:0] a_scan_ch;
    logic       a_busy, a_valid, a_done;
    logic [7:0] b_rd_data, b_scan_data;
    logic [1:0] b_scan_ch;
    logic       b_busy, b_valid, b_done;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: channel contents, registered outputs and edges since scan accept.
    int nch  [2] = '{4, 3};
    int mask [2] = '{15, 255};
    int m_ch   [2][4];
    int m_rd   [2];
    int m_sch  [2];
    int m_sdat [2];
    int m_t    [2];

    chan_dff_bank u_a (
        .clock      (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en_v[0]),
        .wr_ch      (wr_ch_v[0]),
        .wr_data    (wr_data_v[0][3:0]),
        .clr        (clr_v[0]),
        .pst        (pst_v[0]),
        .rd_ch      (rd_ch_v[0]),
        .rd_data    (a_rd_data),
        .scan_start (ss_v[0]),
        .scan_busy  (a_busy),
        .scan_valid (a_valid),
        .scan_ch    (a_scan_ch),
        .scan_data  (a_scan_data),
        .scan_done  (a_done)
    );

    chan_dff_bank #(.WIDTH(8), .NCH(3)) u_b (
        .clock      (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en_v[1]),
        .wr_ch      (wr_ch_v[1]),
        .wr_data    (wr_data_v[1]),
        .clr        (clr_v[1][2:0]),
        .pst        (pst_v[1][2:0]),
        .rd_ch      (rd_ch_v[1]),
        .rd_data    (b_rd_data),
        .scan_start (ss_v[1]),
        .scan_busy  (b_busy),
        .scan_valid (b_valid),
        .scan_ch    (b_scan_ch),
        .scan_data  (b_scan_data),
        .scan_done  (b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int d);
        for (int i = 0; i < 4; i++) m_ch[d][i] = 0;
        m_rd[d] = 0; m_sch[d] = 0; m_sdat[d] = 0; m_t[d] = -1;
    endtask

    // One clock edge of the bank as described by its behavioural rules.
    task automatic model_edge(input int d);
        int  pre [4];
        bit  idle;
        for (int i = 0; i < 4; i++) pre[i] = m_ch[d][i];
        for (int i = 0; i < nch[d]; i++) begin
            if (clr_v[d][i])      m_ch[d][i] = 0;
            else if (pst_v[d][i]) m_ch[d][i] = mask[d];
            else if (wr_en_v[d] && int'(wr_ch_v[d]) == i) m_ch[d][i] = int'(wr_data_v[d]) & mask[d];
        end
        m_rd[d] = (int'(rd_ch_v[d]) < nch[d]) ? pre[rd_ch_v[d]] : 0;
        idle = (m_t[d] < 0) || (m_t[d] > nch[d]);
        if (idle && ss_v[d])  m_t[d] = 0;
        else if (m_t[d] >= 0) m_t[d] = (m_t[d] > 100) ? 100 : m_t[d] + 1;
        if (m_t[d] >= 1 && m_t[d] <= nch[d]) begin
            m_sch[d]  = m_t[d] - 1;
            m_sdat[d] = pre[m_t[d] - 1];
        end
    endtask

    task automatic check_all();
        chk("A.rd_data",    32'(a_rd_data),   m_rd[0]);
        chk("A.scan_busy",  32'(a_busy),      (m_t[0] >= 0 && m_t[0] <= 4) ? 1 : 0);
        chk("A.scan_valid", 32'(a_valid),     (m_t[0] >= 1 && m_t[0] <= 4) ? 1 : 0);
        chk("A.scan_done",  32'(a_done),      (m_t[0] == 5) ? 1 : 0);
        chk("A.scan_ch",    32'(a_scan_ch),   m_sch[0]);
        chk("A.scan_data",  32'(a_scan_data), m_sdat[0]);
        chk("B.rd_data",    32'(b_rd_data),   m_rd[1]);
        chk("B.scan_busy",  32'(b_busy),      (m_t[1] >= 0 && m_t[1] <= 3) ? 1 : 0);
        chk("B.scan_valid", 32'(b_valid),     (m_t[1] >= 1 && m_t[1] <= 3) ? 1 : 0);
        chk("B.scan_done",  32'(b_done),      (m_t[1] == 4) ? 1 : 0);
        chk("B.scan_ch",    32'(b_scan_ch),   m_sch[1]);
        chk("B.scan_data",  32'(b_scan_data), m_sdat[1]);
    endtask

    task automatic step();
        for (int d = 0; d < 2; d++) begin
            if (reset_n) model_edge(d);
            else         model_reset(d);
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Same stimulus to both banks.
    task automatic drive(input logic we, input logic [1:0] wch, input logic [7:0] wd,
                         input logic [3:0] c, input logic [3:0] p,
                         input logic [1:0] rch, input logic ss);
        for (int d = 0; d < 2; d++) begin
            wr_en_v[d] = we; wr_ch_v[d] = wch; wr_data_v[d] = wd;
            clr_v[d] = c; pst_v[d] = p; rd_ch_v[d] = rch; ss_v[d] = ss;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 4'h0, 4'h0, 2'd0, 1'b0);
        model_reset(0);
        model_reset(1);
        #2;
        check_all();
        step();
        step();
        reset_n = 1'b1;

        // Write ch2 then read it back; other channels read zero.
        drive(1'b1, 2'd2, 8'h0A, 4'h0, 4'h0, 2'd0, 1'b0); step();
        drive(1'b0, 2'd0, 8'h00, 4'h0, 4'h0, 2'd2, 1'b0); step();
        chk("dir_rd_ch2", 32'(a_rd_data), 32'h0000000A);
        drive(1'b0, 2'd0, 8'h00, 4'h0, 4'h0, 2'd0, 1'b0); step();
        drive(1'b0, 2'd0, 8'h00, 4'h0, 4'h0, 2'd1, 1'b0); step();
        drive(1'b0, 2'd0, 8'h00, 4'h0, 4'h0, 2'd3, 1'b0); step();

        // Priority: clr beats pst beats write; B ignores wr_ch=3.
        drive(1'b1, 2'd1, 8'h05, 4'b0010, 4'b0010, 2'd0, 1'b0); step();
        drive(1'b1, 2'd3, 8'h05, 4'b0000, 4'b1000, 2'd0, 1'b0); step();
        drive(1'b0, 2'd0, 8'h00, 4'h0, 4'h0, 2'd1, 1'b0); step();
        drive(1'b0, 2'd0, 8'h00, 4'h0, 4'h0, 2'd3, 1'b0); step();
        chk("dir_pst_ch3", 32'(a_rd_data), 32'h0000000F);
        chk("dir_b_oor",   32'(b_rd_data), 32'h00000000);

        // Load 1,2,3,4 and scan with a write to ch0 on the first beat and a re-pulsed start.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(i), 8'(i + 1), 4'h0, 4'h0, 2'd0, 1'b0); step();
        end
        drive(1'b0, 2'd0, 8'h00, 4'h0, 4'h0, 2'd0, 1'b1); step();
        drive(1'b1, 2'd0, 8'h09, 4'h0, 4'h0, 2'd0, 1'b0); step();
        chk("dir_beat0_data", 32'(a_scan_data), 32'h00000001);
        drive(1'b0, 2'd0, 8'h00, 4'h0, 4'h0, 2'd0, 1'b1); step();
        drive(1'b0, 2'd0, 8'h00, 4'h0, 4'h0, 2'd0, 1'b0);
        for (int i = 0; i < 5; i++) step();
        step();
        chk("dir_rd_ch0_new", 32'(a_rd_data), 32'h00000009);

        // Scan aborted by reset after the second beat.
        drive(1'b0, 2'd0, 8'h00, 4'h0, 4'h0, 2'd0, 1'b1); step();
        drive(1'b0, 2'd0, 8'h00, 4'h0, 4'h0, 2'd0, 1'b0); step(); step();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset(0);
        model_reset(1);
        check_all();
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) step();

        // Randomized traffic, independent per bank.
        for (int n = 0; n < 500; n++) begin
            for (int d = 0; d < 2; d++) begin
                wr_en_v[d]   = 1'($urandom_range(0, 1));
                wr_ch_v[d]   = 2'($urandom_range(0, 3));
                wr_data_v[d] = 8'($urandom);
                clr_v[d]     = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
                pst_v[d]     = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
                rd_ch_v[d]   = 2'($urandom_range(0, 3));
                ss_v[d]      = ($urandom_range(0, 4) == 0);
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
